// File: rtl/axi_lite_master_if.sv
// Command/response stream plus AXI4-Lite (AW, W, B, AR, R) signal bundle for axi_lite_master.
// The master modport is the initiator's view; the slave modport is the peer driving commands and AXI ready/response.
interface axi_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [ADDR_WIDTH-1:0] axi_awaddr;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [DATA_WIDTH-1:0] axi_wdata;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [DATA_WIDTH-1:0] axi_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_bready,
    output axi_arvalid, axi_araddr, axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_bready,
    input  axi_arvalid, axi_araddr, axi_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Every output is a flop whose next value is decoded from the next FSM state.
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  axi_lite_master_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR,
    StRsp
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_set, w_set;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_write_d = rsp_write_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_set      = aw_done_q | (awvalid_q & bus.axi_awready);
    w_set       = w_done_q | (wvalid_q & bus.axi_wready);

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is low for the first cycle out of reset, so nothing is accepted then
        if (cmd_ready_q && bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          state_d = bus.cmd_write ? StWrAwW : StRdAr;
        end
      end
      StWrAwW: begin
        aw_done_d = aw_set;
        w_done_d  = w_set;
        if (aw_set && w_set) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        if (bready_q && bus.axi_bvalid) begin
          rsp_write_d = 1'b1;
          rdata_d     = '0;
          state_d     = StRsp;
        end
      end
      StRdAr: begin
        if (arvalid_q && bus.axi_arready) begin
          state_d = StRdR;
        end
      end
      StRdR: begin
        if (rready_q && bus.axi_rvalid) begin
          rsp_write_d = 1'b0;
          rdata_d     = bus.axi_rdata;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs: decode the state we are about to enter
    cmd_ready_d = (state_d == StIdle);
    awvalid_d   = (state_d == StWrAwW) && !aw_done_d;
    wvalid_d    = (state_d == StWrAwW) && !w_done_d;
    bready_d    = (state_d == StWrB);
    arvalid_d   = (state_d == StRdAr);
    rready_d    = (state_d == StRdR);
    rsp_valid_d = (state_d == StRsp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_write_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_write_q <= rsp_write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_bready  = bready_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_araddr  = addr_q;
  assign bus.axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table of directed transactions against a small register-file
// AXI slave with per-vector stall counts, plus hand-written reset sequences.
module tb_axi_lite_master;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct {
    string       name;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          aw_dly;
    int          w_dly;
    int          r_dly;
    int          rsp_dly;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_aw_hi;
    int          exp_w_hi;
    int          exp_r_hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [32];
  vec_t        vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.rsp_ready   = 1'b0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_bvalid  = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s ctrl", tag), {24'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_write,
          bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready}, 0);
    check($sformatf("%s data", tag), bus.rsp_rdata | bus.axi_wdata, 0);
    check($sformatf("%s addr", tag), {22'd0, bus.axi_awaddr, bus.axi_araddr}, 0);
  endtask

  // Issue one command and act as the AXI slave, one step per cycle at posedge+1
  task automatic run_vec(input vec_t v);
    int          aw_hi = 0, w_hi = 0, r_hi = 0, lat = -1, rsp_cnt = 0;
    int          addr_bad = 0, order_bad = 0, rsp_bad = 0;
    bit          aw_tb = 0, w_tb = 0, ar_tb = 0, hs = 0, done = 0, ok = 0;
    logic        got_wr = 1'b0;
    logic [31:0] got_rdata = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check($sformatf("%s cmd_ready", v.name), {31'd0, ok}, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
      bus.axi_awready = 1'b0;
      bus.axi_wready  = 1'b0;
      bus.axi_bvalid  = 1'b0;
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = '0;
      bus.rsp_ready   = 1'b0;
      if (hs) begin
        if (bus.rsp_valid || !bus.cmd_ready) rsp_bad++;
        done = 1;
      end else begin
        if (v.wr && (bus.axi_arvalid || bus.axi_rready)) order_bad++;
        if (!v.wr && (bus.axi_awvalid || bus.axi_wvalid || bus.axi_bready)) order_bad++;
        if (bus.axi_awvalid) begin
          if (aw_tb) order_bad++;
          if (bus.axi_awaddr !== v.addr) addr_bad++;
          aw_hi++;
          if (aw_hi > v.aw_dly) begin
            bus.axi_awready = 1'b1;
            aw_tb = 1;
          end
        end
        if (bus.axi_wvalid) begin
          if (w_tb) order_bad++;
          if (bus.axi_wdata !== v.wdata) addr_bad++;
          w_hi++;
          if (w_hi > v.w_dly) begin
            bus.axi_wready = 1'b1;
            w_tb = 1;
          end
        end
        if (bus.axi_bready) begin
          if (!(aw_tb && w_tb)) order_bad++;
          bus.axi_bvalid = 1'b1;
          mem[v.addr] = v.wdata;
        end
        if (bus.axi_arvalid) begin
          if (ar_tb) order_bad++;
          if (bus.axi_araddr !== v.addr) addr_bad++;
          bus.axi_arready = 1'b1;
          ar_tb = 1;
        end
        if (bus.axi_rready) begin
          if (!ar_tb) order_bad++;
          r_hi++;
          if (r_hi > v.r_dly) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = mem[v.addr];
          end
        end
        if (bus.rsp_valid) begin
          if (lat < 0) begin
            lat       = cyc;
            got_wr    = bus.rsp_write;
            got_rdata = bus.rsp_rdata;
          end else if (bus.rsp_write !== got_wr || bus.rsp_rdata !== got_rdata) begin
            rsp_bad++;
          end
          if (bus.cmd_ready || bus.axi_awvalid || bus.axi_wvalid || bus.axi_arvalid) rsp_bad++;
          rsp_cnt++;
          if (rsp_cnt > v.rsp_dly) begin
            bus.rsp_ready = 1'b1;
            bus.cmd_valid = 1'b0;
            hs = 1;
          end else begin
            // Hold a pending command while the response is stalled; it must not be taken
            bus.cmd_valid = 1'b1;
          end
        end
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    idle_inputs();
    check($sformatf("%s completed", v.name), {31'd0, done}, 1);
    check($sformatf("%s rsp_write", v.name), {31'd0, got_wr}, {31'd0, v.exp_wr});
    check($sformatf("%s rsp_rdata", v.name), got_rdata, v.exp_rdata);
    check($sformatf("%s latency", v.name), lat, v.exp_lat);
    check($sformatf("%s awvalid_cycles", v.name), aw_hi, v.exp_aw_hi);
    check($sformatf("%s wvalid_cycles", v.name), w_hi, v.exp_w_hi);
    check($sformatf("%s rready_cycles", v.name), r_hi, v.exp_r_hi);
    check($sformatf("%s addr_data_stable", v.name), addr_bad, 0);
    check($sformatf("%s channel_order", v.name), order_bad, 0);
    check($sformatf("%s rsp_stable", v.name), rsp_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   seen;
    vec_t post;
    idle_inputs();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[16] = 32'hDEAD_BEEF;

    // name, wr, addr, wdata, aw/w/r/rsp stalls, exp wr, exp rdata, latency, aw/w/r valid cycles
    vecs[0] = '{"wr_basic",      1'b1, 5'h04, 32'h0000_1234, 0, 0, 0, 0, 1'b1, 32'h0,         3, 1, 1, 0};
    vecs[1] = '{"wr_aw_skew",    1'b1, 5'h08, 32'hA5A5_0001, 3, 0, 0, 0, 1'b1, 32'h0,         6, 4, 1, 0};
    vecs[2] = '{"wr_w_skew",     1'b1, 5'h0C, 32'h0000_5A5A, 0, 3, 0, 0, 1'b1, 32'h0,         6, 1, 4, 0};
    vecs[3] = '{"wr_both_late",  1'b1, 5'h14, 32'h1357_9BDF, 2, 2, 0, 0, 1'b1, 32'h0,         5, 3, 3, 0};
    vecs[4] = '{"rd_slow",       1'b0, 5'h10, 32'h0,         0, 0, 5, 0, 1'b0, 32'hDEAD_BEEF, 8, 0, 0, 6};
    vecs[5] = '{"rd_backpress",  1'b0, 5'h04, 32'hFFFF_FFFF, 0, 0, 0, 4, 1'b0, 32'h0000_1234, 3, 0, 0, 1};
    vecs[6] = '{"pwm_wr_period", 1'b1, 5'h04, 32'h0000_0100, 0, 0, 0, 0, 1'b1, 32'h0,         3, 1, 1, 0};
    vecs[7] = '{"pwm_wr_duty",   1'b1, 5'h08, 32'h0000_0040, 0, 0, 0, 0, 1'b1, 32'h0,         3, 1, 1, 0};
    vecs[8] = '{"pwm_rd_period", 1'b0, 5'h04, 32'h0,         0, 0, 0, 0, 1'b0, 32'h0000_0100, 3, 0, 0, 1};
    vecs[9] = '{"pwm_rd_duty",   1'b0, 5'h08, 32'h0,         0, 0, 1, 2, 1'b0, 32'h0000_0040, 4, 0, 0, 2};

    // Power-on reset
    #23;
    check_all_zero("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("por cmd_ready_after_release", {31'd0, bus.cmd_ready}, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while a read address is outstanding (slave never grants AR)
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h10;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("mid_rst arvalid_before", {31'd0, bus.axi_arvalid}, 1);
    check("mid_rst araddr_before", {27'd0, bus.axi_araddr}, 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) check("mid_rst cmd_ready_after_release", {31'd0, bus.cmd_ready}, 1);
      if (bus.rsp_valid || bus.axi_arvalid || bus.axi_rready) seen++;
    end
    check("mid_rst no_response", seen, 0);

    post = '{"post_rst_read", 1'b0, 5'h10, 32'h0, 0, 0, 0, 0, 1'b0, 32'hDEAD_BEEF, 3, 0, 0, 1};
    run_vec(post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite write and read transactions. It is the initiator-side counterpart of the PWM peripheral's AXI4-Lite slave port. Typical uses: the integration testbench, and an on-chip sequencer that programs prescale, period and duty registers. The AXI signal set matches the slave exactly: AW, W, B and AR, R channels with valid, ready, address and data only. There are no PROT, STRB or RESP signals.

## Interface
- ADDR_WIDTH, 5, AXI address width
- DATA_WIDTH, 32, AXI data width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data; ignored on reads
- rsp_valid  out  1  transaction complete
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- axi_awvalid  out  1 / axi_awready  in  1 / axi_awaddr  out  ADDR_WIDTH  write address channel
- axi_wvalid  out  1 / axi_wready  in  1 / axi_wdata  out  DATA_WIDTH  write data channel
- axi_bvalid  in  1 / axi_bready  out  1  write response channel
- axi_arvalid  out  1 / axi_arready  in  1 / axi_araddr  out  ADDR_WIDTH  read address channel
- axi_rvalid  in  1 / axi_rready  out  1 / axi_rdata  in  DATA_WIDTH  read data channel

## Operation
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_addr, cmd_wdata and cmd_write.
  - Go to WR_AW_W if write, else RD_AR.
- WR_AW_W:
  - axi_awvalid = !aw_done and axi_wvalid = !w_done.
  - Each channel handshake sets its done flag. That valid then drops on the next cycle; the other channel is unaffected.
  - When both are done, clear the flags and go to WR_B. This covers both handshakes in the same cycle and either order.
- WR_B: axi_bready = 1. On axi_bvalid, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- RD_AR: axi_arvalid = 1. On axi_arready, go to RD_R.
- RD_R: axi_rready = 1. On axi_rvalid, capture axi_rdata into rsp_rdata, set rsp_write = 0, then go to RSP.
- RSP: rsp_valid = 1. On rsp_ready, go to IDLE.
- Exactly one transaction is in flight at any time. cmd_ready is low in every state except IDLE.
- axi_awaddr, axi_araddr and axi_wdata drive the latched values. They are stable for as long as the corresponding valid is high.
- Once asserted, a valid is never dropped before its handshake completes.
- axi_bvalid outside WR_B and axi_rvalid outside RD_R are ignored; the matching ready stays low.
- All AXI and response outputs are registered. No combinational path from any input to any output.
- Reset (asynchronous):
  - FSM returns to IDLE.
  - All valid and ready outputs go to 0; data and address outputs go to 0.
  - cmd_ready = 1 from the first clock edge after rst_n deasserts.
  - Reset in the middle of a transaction abandons it. No response is produced.

## Timing
- Command accepted at edge N; the valid(s) for the transaction are high from cycle N+1.
- Write, all ready signals high:
  - AW and W handshake at N+1.
  - axi_bready high at N+2; axi_bvalid at N+2.
  - rsp_valid at N+3. Minimum write latency is 3 cycles.
- Read, all ready signals high:
  - AR handshake at N+1.
  - axi_rready high at N+2; axi_rvalid at N+2.
  - rsp_valid at N+3. Minimum read latency is 3 cycles.
- rsp_valid/rsp_ready handshake at M: cmd_ready is high at M+1.
  - Peak throughput is one transaction per 4 cycles.
- Every wait on the slave extends the corresponding state by one cycle per stall cycle. There is no timeout.

## Test plan
- Write with an always-ready slave: cmd addr 0x04, data 0x0000_1234.
  - AW and W handshake at N+1 with axi_awaddr = 0x04 and axi_wdata = 0x1234.
  - axi_bready at N+2; rsp_valid at N+3 with rsp_write = 1.
- Skewed write, axi_awready delayed 3 cycles, axi_wready immediate:
  - axi_wvalid is high for exactly 1 cycle.
  - axi_awvalid is high for 4 cycles with a stable address.
  - axi_bready rises only after the AW handshake.
  - Repeat with the skew reversed; same result with the roles swapped.
- Read with axi_rvalid delayed 5 cycles, axi_rdata = 0xDEAD_BEEF:
  - axi_rready is held high throughout RD_R.
  - rsp_rdata = 0xDEADBEEF and rsp_write = 0.
- Response backpressure, rsp_ready low for 4 cycles:
  - rsp_valid and rsp_rdata stay stable.
  - cmd_ready stays 0 and no AXI valid is asserted while cmd_valid is held.
- Reset pulse while axi_arvalid is high:
  - All outputs are 0 immediately, with no clock edge needed.
  - No rsp_valid is produced.
  - cmd_ready = 1 after release, and the next read completes normally.
- Integration with the PWM peripheral:
  - Write period 0x0100 and duty 0x0040 to channel 0, then read both back.
  - rsp_rdata returns 0x0100 and 0x0040.
